// File: rtl/dmem_port_if.sv
// Requester-side handshake bundle for one data-RAM port.
// The requester holds req until done; we/addr/wdata are stable while req is high.
interface dmem_port_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;

    modport master (output req, we, addr, wdata, input rdata, done);
    modport slave  (input req, we, addr, wdata, output rdata, done);
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter between the integer MEM stage (port 0) and the FPU LSU (port 1)
// for a registered-I/O single-port data RAM; one RAM access per grant.
module dmem_port_arbiter #(
    parameter int AW     = 5,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          clrn,
    dmem_port_if.slave    m0,
    dmem_port_if.slave    m1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAP, DONE} state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic             last_gnt;
    logic             cmd_port;
    logic             cmd_we;
    logic [1:0][31:0] rdata_q;
    logic [1:0]       done_q;

    logic        pick;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // Under contention the port that did not win last time gets the grant.
    assign pick      = (m0.req & m1.req) ? ~last_gnt : m1.req;
    assign sel_we    = pick ? m1.we    : m0.we;
    assign sel_addr  = pick ? m1.addr  : m0.addr;
    assign sel_wdata = pick ? m1.wdata : m0.wdata;

    assign m0.rdata = rdata_q[0];
    assign m1.rdata = rdata_q[1];
    assign m0.done  = done_q[0];
    assign m1.done  = done_q[1];

    // Byte-lane and out-of-range address bits are deliberately dropped: accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0.addr[31:AW+2], m0.addr[1:0], m1.addr[31:AW+2], m1.addr[1:0]};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            cnt       <= '0;
            last_gnt  <= 1'b1;
            cmd_port  <= 1'b0;
            cmd_we    <= 1'b0;
            rdata_q   <= '0;
            done_q    <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (m0.req | m1.req) begin
                        cmd_port  <= pick;
                        cmd_we    <= sel_we;
                        mem_addr  <= sel_addr[AW+1:2];
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    if (cmd_we) begin
                        done_q[cmd_port] <= 1'b1;
                        state            <= DONE;
                    end else if (RD_LAT == 1) begin
                        state <= CAP;
                    end else begin
                        cnt   <= 3'(RD_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= CAP;
                end
                CAP: begin
                    rdata_q[cmd_port] <= mem_rdata;
                    done_q[cmd_port]  <= 1'b1;
                    state             <= DONE;
                end
                DONE: begin
                    last_gnt <= cmd_port;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random rounds, checked against a
// transaction-level model of grant order, completion cycles and RAM contents.
module tb_dmem_port_arbiter;
    localparam int AW     = 5;
    localparam int RD_LAT = 2;

    logic          clk;
    logic          clrn;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;

    dmem_port_if m0_if ();
    dmem_port_if m1_if ();

    dmem_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-address, registered-output RAM (two-cycle read).
    logic          ram_clr;
    logic [31:0]   ram [32];
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_q;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
            ram_a <= '0;
            ram_q <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            ram_a <= mem_addr;
            ram_q <= ram[ram_a];
        end
    end
    assign mem_rdata = ram_q;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [32];
    logic [31:0] exp_rd [2];
    int          mdl_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
        end
    endtask

    // One round: requests raised together in an IDLE cycle, each port served once.
    task automatic do_round(input bit r0, input bit r1, input bit w0, input bit w1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input bit early_drop);
        bit          rq [2];
        bit          wq [2];
        logic [31:0] aq [2];
        logic [31:0] dq [2];
        int          icyc [2];
        int          dcyc [2];
        int          first, t, last;
        bit          busy_e, we_e;
        rq = '{r0, r1}; wq = '{w0, w1}; aq = '{a0, a1}; dq = '{d0, d1};
        icyc = '{-1, -1}; dcyc = '{-1, -1};
        if (r0 && r1) first = (mdl_last == 1) ? 0 : 1;
        else          first = r0 ? 0 : 1;
        icyc[first] = 1;
        dcyc[first] = wq[first] ? 2 : RD_LAT + 2;
        last = dcyc[first];
        if (r0 && r1) begin
            t = dcyc[first] + 1;
            icyc[1-first] = t + 1;
            dcyc[1-first] = t + (wq[1-first] ? 2 : RD_LAT + 2);
            last = dcyc[1-first];
        end
        @(posedge clk); #1;
        drive(0, r0, w0, a0, d0);
        drive(1, r1, w1, a1, d1);
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clk);
            busy_e = 1'b0; we_e = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (c == dcyc[p]) begin
                    mdl_last = p;
                    if (wq[p]) ref_mem[aq[p][AW+1:2]] = dq[p];
                    else       exp_rd[p] = ref_mem[aq[p][AW+1:2]];
                end
                if (dcyc[p] >= 0 && c >= icyc[p] && c <= dcyc[p]) busy_e = 1'b1;
                if (c == icyc[p] && wq[p]) we_e = 1'b1;
            end
            chk("done0", {31'd0, m0_if.done}, {31'd0, c == dcyc[0]});
            chk("done1", {31'd0, m1_if.done}, {31'd0, c == dcyc[1]});
            chk("busy", {31'd0, busy}, {31'd0, busy_e});
            chk("mem_we", {31'd0, mem_we}, {31'd0, we_e});
            chk("rdata0", m0_if.rdata, exp_rd[0]);
            chk("rdata1", m1_if.rdata, exp_rd[1]);
            for (int p = 0; p < 2; p++) begin
                if (c == icyc[p]) begin
                    chk("mem_addr", 32'(mem_addr), 32'(aq[p][AW+1:2]));
                    if (wq[p]) chk("mem_wdata", mem_wdata, dq[p]);
                end
                if (c == dcyc[p]) drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (early_drop && c == 2) begin
                drive(0, 1'b0, 1'b1, $urandom, $urandom);
                drive(1, 1'b0, 1'b1, $urandom, $urandom);
            end
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        bit [1:0] r;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        exp_rd = '{32'h0, 32'h0};
        mdl_last = 1;

        // T1: reset holds every output low regardless of inputs
        clrn = 1'b0; ram_clr = 1'b1;
        drive(0, 1'b1, 1'b1, $urandom, $urandom);
        drive(1, 1'b1, 1'b1, $urandom, $urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata0", m0_if.rdata, 32'd0);
        chk("rst_rdata1", m1_if.rdata, 32'd0);
        chk("rst_done", {30'd0, m1_if.done, m0_if.done}, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        clrn = 1'b1; ram_clr = 1'b0;
        do_round(1, 1, 0, 0, 32'h0, 32'h4, 32'h0, 32'h0, 0);

        // T2: store then load on port 0
        do_round(1, 0, 1, 0, 32'h0C, 32'h0, 32'hDEADBEEF, 32'h0, 0);
        do_round(1, 0, 0, 0, 32'h0C, 32'h0, 32'h0, 32'h0, 0);

        // T3: back-to-back contention, grants must alternate
        do_round(1, 1, 1, 0, 32'h10, 32'h0C, 32'h11111111, 32'h0, 0);
        do_round(1, 1, 0, 1, 32'h10, 32'h14, 32'h0, 32'h22222222, 0);
        do_round(0, 1, 1, 0, 32'h0, 32'h18, 32'h0, 32'h0, 0);
        do_round(1, 1, 0, 0, 32'h14, 32'h10, 32'h0, 32'h0, 0);

        // T4: address wrap and ignored byte-offset bits
        do_round(0, 1, 0, 1, 32'h0, 32'h80, 32'h0, 32'h1234, 0);
        do_round(1, 0, 0, 0, 32'h00, 32'h0, 32'h0, 32'h0, 0);
        do_round(0, 1, 0, 1, 32'h0, 32'hFFFF_FF8C, 32'h0, 32'h3333, 0);
        do_round(1, 0, 0, 0, 32'h0E, 32'h0, 32'h0, 32'h0, 0);

        // T5: requester abandons req mid-load, transaction still completes
        do_round(0, 1, 0, 0, 32'h0, 32'h0C, 32'h0, 32'h0, 1);

        // T6: reset during WAIT aborts the load without a done pulse
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        repeat (3) @(negedge clk);
        chk("t6_busy_pre", {31'd0, busy}, 32'd1);
        #1 clrn = 1'b0;
        #1;
        chk("t6_busy_rst", {31'd0, busy}, 32'd0);
        chk("t6_done_rst", {30'd0, m1_if.done, m0_if.done}, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6_done_after", {30'd0, m1_if.done, m0_if.done}, 32'd0);
        clrn = 1'b1;
        mdl_last = 1;
        exp_rd = '{32'h0, 32'h0};
        do_round(1, 1, 0, 0, 32'h10, 32'h0C, 32'h0, 32'h0, 0);

        // Random rounds
        for (int n = 0; n < 40; n++) begin
            r = 2'($urandom_range(1, 3));
            do_round(r[0], r[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
                     $urandom, $urandom, 0);
            idle_gap(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
